// File: rtl/mac_pkg.sv
// Shared constants for the MAC datapath and the dot-product sequencer state encoding.
package mac_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_FETCH = FETCH,
        ST_WAIT  = WAIT,
        ST_DONE  = DONE
    } state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams N operand pairs through an external mac_unit,
// feeding the running accumulator back as c, and returns acc over valid/ready.
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ACC_W-1:0]  bias,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [OP_W-1:0]   mac_a,
    output logic [OP_W-1:0]   mac_b,
    output logic [ACC_W-1:0]  mac_c,
    input  logic [ACC_W-1:0]  mac_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_result
);

    localparam int TMR_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [TMR_W-1:0]   timer_q;
    logic [OP_W-1:0]    mac_a_q;
    logic [OP_W-1:0]    mac_b_q;
    logic [ACC_W-1:0]   mac_c_q;
    logic [ACC_W-1:0]   result_q;
    logic               busy_q;
    logic               in_ready_q;
    logic               out_valid_q;

    // Status outputs are registered alongside the state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        remaining_q <= len;
                        acc_q       <= bias;
                        busy_q      <= 1'b1;
                        if (len != '0) begin
                            state_q    <= ST_FETCH;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_DONE;
                            result_q    <= bias;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (in_valid && in_ready_q) begin
                        mac_a_q     <= in_a;
                        mac_b_q     <= in_b;
                        mac_c_q     <= acc_q;
                        remaining_q <= remaining_q - LEN_W'(1);
                        timer_q     <= TMR_W'(MAC_LAT);
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Timer reaches zero exactly when mac_y reflects the issued operands.
                    if (timer_q == '0) begin
                        acc_q <= mac_y;
                        if (remaining_q != '0) begin
                            state_q    <= ST_FETCH;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= ST_DONE;
                            result_q    <= mac_y;
                            out_valid_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;
    assign mac_c      = mac_c_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq with a behavioural MAC_LAT-stage mac_unit model.
module tb_mac_dot_seq;

    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [15:0]       bias;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_a;
    logic [7:0]        in_b;
    logic [7:0]        mac_a;
    logic [7:0]        mac_b;
    logic [15:0]       mac_c;
    logic [15:0]       mac_y;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_hi = 0;
    int txn   = 0;
    int h1, h2, h3;
    logic [15:0] exp_q [$];
    logic [15:0] pipe_q [MAC_LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .bias(bias), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_y(mac_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    // mac_unit stand-in: y = a*b + c, MAC_LAT register stages after the operand registers
    always @(posedge clk) begin
        pipe_q[0] <= 16'(mac_a) * 16'(mac_b) + mac_c;
        for (int i = 1; i < MAC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign mac_y = pipe_q[MAC_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted result, checks stability while held.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_ready) rdy_hi++;
            if (in_ready && (!busy || out_valid)) begin
                total++; bad++;
                $display("FAIL in_ready_outside_fetch: got=1 required=0");
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_result: got=%h required=none", out_result);
                end else if (out_ready) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    txn++;
                    total++;
                    if (out_result !== e) begin
                        bad++;
                        $display("FAIL result_%0d: got=%h required=%h", txn, out_result, e);
                    end else begin
                        $display("result %0d: got=%h exp=%h", txn, out_result, e);
                    end
                end else begin
                    total++;
                    if (out_result !== exp_q[0]) begin
                        bad++;
                        $display("FAIL result_held: got=%h required=%h", out_result, exp_q[0]);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [LEN_W-1:0] l, input logic [15:0] b);
        start = 1'b1; len = l; bias = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input int gap, output int hs);
        repeat (gap) begin @(posedge clk); #1; end
        in_a = a; in_b = b; in_valid = 1'b1; hs = -1;
        for (int i = 0; i < 64 && hs < 0; i++) begin
            @(negedge clk);
            if (in_ready) hs = cyc + 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (hs < 0) begin
            total++; bad++;
            $display("FAIL operand_timeout: got=no_handshake required=handshake");
        end
    endtask

    task automatic collect(input int hold);
        int n;
        n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL result_timeout: got=no_valid required=valid");
        end
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("busy_after_accept", 32'(busy), 0);
        chk("valid_after_accept", 32'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; bias = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_mac_a", 32'(mac_a), 0);
        chk("rst_mac_b", 32'(mac_b), 0);
        chk("rst_mac_c", 32'(mac_c), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // basic: 20 + 5*10 + 2*3 = 76
        exp_q.push_back(16'd76);
        issue(8'd2, 16'd20);
        chk("busy_after_start", 32'(busy), 1);
        chk("in_ready_in_fetch", 32'(in_ready), 1);
        send(8'd5, 8'd10, 0, h1);
        send(8'd2, 8'd3, 0, h2);
        chk("spacing_b2b", 32'(h2 - h1), 32'(MAC_LAT + 2));
        chk("mac_a_issued", 32'(mac_a), 2);
        chk("mac_b_issued", 32'(mac_b), 3);
        chk("mac_c_issued", 32'(mac_c), 70);
        collect(3);

        // wrap cases
        exp_q.push_back(16'h0000);
        issue(8'd1, 16'hFFFF);
        send(8'd1, 8'd1, 0, h1);
        collect(0);
        exp_q.push_back(16'hFE01);
        issue(8'd1, 16'h0000);
        send(8'd255, 8'd255, 0, h1);
        collect(0);

        // zero length
        rdy_hi = 0;
        exp_q.push_back(16'd7);
        issue(8'd0, 16'd7);
        chk("zlen_valid_next_edge", 32'(out_valid), 1);
        chk("zlen_result", 32'(out_result), 7);
        collect(2);
        chk("zlen_no_in_ready", 32'(rdy_hi), 0);
        chk("mac_a_held_across_ops", 32'(mac_a), 255);

        // gapped operands and output backpressure: 1*2 + 3*4 + 5*6 = 44
        exp_q.push_back(16'd44);
        issue(8'd3, 16'd0);
        send(8'd1, 8'd2, 4, h1);
        send(8'd3, 8'd4, 4, h2);
        send(8'd5, 8'd6, 4, h3);
        chk("spacing_gap_1", 32'(h2 - h1 >= MAC_LAT + 2), 1);
        chk("spacing_gap_2", 32'(h3 - h2 >= MAC_LAT + 2), 1);
        collect(5);

        // start during WAIT is ignored: 10 + 9 + 16 = 35
        exp_q.push_back(16'd35);
        issue(8'd2, 16'd10);
        send(8'd3, 8'd3, 0, h1);
        start = 1'b1; len = 8'd1; bias = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        send(8'd4, 8'd4, 0, h2);
        collect(0);
        exp_q.push_back(16'd101);
        issue(8'd1, 16'd100);
        send(8'd1, 8'd1, 0, h1);
        collect(0);

        // reset during the second WAIT aborts the command
        issue(8'd3, 16'd50);
        send(8'd1, 8'd1, 0, h1);
        send(8'd2, 8'd2, 0, h2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_mac_c", 32'(mac_c), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        repeat (4) begin @(posedge clk); #1; end
        exp_q.push_back(16'd5);
        issue(8'd1, 16'd1);
        send(8'd2, 8'd2, 0, h1);
        collect(0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
